// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Digit counter width; never narrower than one bit.
    function automatic int cnt_w(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder, chained DIGIT times per cycle
// inside serial_adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder, DIGIT bits per clock, LSB first, registered carry.
// Optional subtract mode via the SERIAL_ADDER_SUB_EN macro.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_w(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nx;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] ds;
    logic [DIGIT:0]   c;
    logic             b_inv;
    logic             accept;
    logic             last;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_inv = sub;
`else
    assign b_inv = 1'b0;
`endif

    assign busy   = (state == RUN);
    assign accept = (state == IDLE) && start;
    assign last   = busy && (cnt_q == LAST);

    assign c[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_rip
        fa_cell u_fa (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .ci (c[i]),
            .s  (ds[i]),
            .co (c[i+1])
        );
    end

    // Result digits land in place so the final digit can be merged on the
    // completing edge without a partial value ever reaching sum.
    always_comb begin
        res_nx = res_q;
        res_nx[cnt_q*DIGIT +: DIGIT] = ds;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (cnt_q == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q     <= a;
                b_q     <= b ^ {WIDTH{b_inv}};
                carry_q <= cin ^ b_inv;
                cnt_q   <= '0;
            end else if (busy) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                carry_q <= c[DIGIT];
                cnt_q   <= cnt_q + 1'b1;
                res_q   <= res_nx;
                if (last) begin
                    sum  <= res_nx;
                    cout <= c[DIGIT];
                    ovf  <= c[DIGIT] ^ c[DIGIT-1];
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder: W8/D1 instance plus a
// W8/D4 instance (subtract case when SERIAL_ADDER_SUB_EN is defined).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start4 = 1'b0;
    logic [7:0] a4 = '0;
    logic [7:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       sub4 = 1'b0;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;

`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub4),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    // Reference: {sum, cout, ovf} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mc, input logic ms);
        logic [7:0] be;
        logic [8:0] full;
        logic       c0;
        logic       v;
        be   = ms ? ~mb : mb;
        c0   = ms ? ~mc : mc;
        full = {1'b0, ma} + {1'b0, be} + {8'd0, c0};
        v    = (ma[7] == be[7]) && (full[7] != ma[7]);
        return {full[7:0], full[8], v};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_cmp(input string tag, input logic [9:0] got);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed %h with empty scoreboard", tag, got);
        end else begin
            check(tag, {22'd0, got}, {22'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] ta,
                         input logic [7:0] tb_, input logic tc);
        int cyc;
        logic [7:0] held;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        exp_q.push_back(model(ta, tb_, tc, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ~tb_;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, 8);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        pop_cmp({tag, "_res"}, {sum, cout, ovf});
        held = sum;
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, {24'd0, sum}, {24'd0, held});
    endtask

    initial begin
        int nd;
        int first_at;
        int second_at;
        int cyc;

        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_res", {22'd0, sum, cout, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("t1", 8'h3C, 8'h05, 1'b0);
        do_op("t2", 8'hFF, 8'h01, 1'b0);
        do_op("t3", 8'h7F, 8'h01, 1'b0);
        do_op("t4", 8'hFF, 8'hFF, 1'b1);

        // Start held high through a run: second op taken in the done cycle.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
        @(posedge clk); #1;
        a = 8'hA5; b = 8'h3C; cin = 1'b1;
        exp_q.push_back(model(8'hA5, 8'h3C, 1'b1, 1'b0));
        nd = 0; first_at = 0; second_at = 0;
        for (int i = 1; i <= 22; i++) begin
            @(posedge clk); #1;
            if (i == 9) start = 1'b0;
            if (done) begin
                nd++;
                if (nd == 1) first_at = i;
                if (nd == 2) second_at = i;
                pop_cmp("t5_res", {sum, cout, ovf});
            end
        end
        check("t5_ndone", nd, 2);
        check("t5_first", first_at, 8);
        check("t5_second", second_at, 17);

        // Abort mid-run with an asynchronous reset.
        @(negedge clk);
        a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h55, 8'h22, 1'b0, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_res", {22'd0, sum, cout, ovf}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("t6_nodone", nd, 0);
        do_op("t6_after", 8'h12, 8'h34, 1'b1);

        // Four bits per cycle instance.
        @(negedge clk);
        a4 = 8'h05; b4 = 8'h07; cin4 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub4 = 1'b1;
`else
        sub4 = 1'b0;
`endif
        start4 = 1'b1;
        exp_q.push_back(model(8'h05, 8'h07, 1'b0, sub4));
        @(posedge clk); #1;
        start4 = 1'b0;
        check("t7_busy", {31'd0, busy4}, 32'd1);
        cyc = 0;
        while (!done4 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t7_lat", cyc, 2);
        pop_cmp("t7_res", {sum4, cout4, ovf4});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
